data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Responder side of the CPU data-memory port. Accepts one word-sized read or
//   write request per handshake and returns a response after a programmable
//   latency. It replaces the zero-latency data memory so the datapath can be
//   exercised against realistic memory stalls. Sits between the CPU MEM stage
//   and word storage; the CPU stalls while ready_o is low.
// PARAMETERS
//   DEPTH    256  number of 32-bit words stored (power of two, >= 2)
//   LATENCY  2    cycles from request acceptance to valid_o (1..15)
// PORTS
//   clk_i    in   1   clock, rising edge
//   rst_i    in   1   reset, synchronous, active-high
//   req_i    in   1   request present
//   we_i     in   1   1 = write, 0 = read; sampled with req_i
//   addr_i   in   32  byte address
//   data_i   in   32  write data
//   ready_o  out  1   responder can accept a request this cycle
//   valid_o  out  1   one-cycle response strobe, for both reads and writes
//   data_o   out  32  read data, qualified by valid_o
//   err_o    out  1   access fault, qualified by valid_o
// BEHAVIOUR
//   - One clock (clk_i). Reset is synchronous and active-high (rst_i).
//   - Reset values: ready_o=1 from the first cycle after rst_i drops; valid_o=0,
//     data_o=0, err_o=0, state=IDLE, counter=0. Storage contents are not reset.
//   - States: IDLE, WAIT, RESP.
//   - Acceptance: a request is taken at a rising edge when req_i & ready_o.
//     addr_i, we_i and data_i are captured into holding registers on that edge.
//   - IDLE: ready_o=1. On acceptance -> WAIT with cnt=LATENCY-1. If LATENCY=1,
//     go directly to RESP.
//   - WAIT: ready_o=0. cnt decrements each cycle; when cnt=1 -> RESP.
//     req_i is ignored in this state.
//   - RESP: valid_o=1 for exactly one cycle, ready_o=1.
//     - A request accepted in RESP goes to WAIT or RESP as from IDLE
//       (back-to-back). Otherwise -> IDLE.
//   - Timing: for a request accepted at edge T, valid_o is high during cycle
//     T+LATENCY. Peak throughput is one request per LATENCY cycles.
//   - Address decode: word index = addr[log2(DEPTH)+1:2].
//     - err when addr[1:0]!=0 (misaligned) or any of addr[31:log2(DEPTH)+2]
//       is nonzero (out of range).
//   - Write commit: storage is written on the edge entering RESP, only if there
//     is no err. The response has data_o=0.
//   - Read response: data_o = storage[index] as of the edge entering RESP, or 0
//     on err. data_o holds its value until the next response.
//   - Read-after-write to the same word, back-to-back: the read returns the new
//     data, because the write commits before the read is serviced.
//   - err_o is valid only when valid_o=1. It is 0 whenever valid_o=0.
//   - Reset mid-operation: a pending request is dropped, with no valid_o and
//     no write commit.
//   - Outputs are registered. No combinational path from req_i to ready_o.
// STRUCTURE
//   - Shared package mem_if_pkg:
//     - WORD_W=32
//     - state encoding IDLE=2'd0, WAIT=2'd1, RESP=2'd2
//     - CNT_W=4
//   - Sub-module dmem_array: single-port synchronous word RAM (DEPTH x 32) with
//     we/idx/wdata/rdata ports. The FSM, counter and decode stay in the top.
// TESTING
//   - Reset: hold rst_i 2 cycles mid-WAIT -> no valid_o afterwards; ready_o=1
//     on the first cycle after release.
//   - Write then read, LATENCY=2: write 0xDEADBEEF @0x10 -> valid_o at T+2 with
//     err_o=0; read @0x10 -> data_o=0xDEADBEEF.
//   - Back-to-back: write 0x12345678 @0x20, then read @0x20 accepted in the
//     RESP cycle -> second valid_o exactly 2 cycles later, data_o=0x12345678.
//   - Misaligned read @0x13 -> valid_o with err_o=1, data_o=0; the word at 0x10
//     is unchanged.
//   - Out of range, DEPTH=256: write @0x400 -> err_o=1; a following read @0x0
//     returns its prior value, proving no wrap-around.
//   - LATENCY=1 and LATENCY=15: valid_o asserted exactly LATENCY cycles after
//     acceptance; req_i held high during WAIT is not re-accepted.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared definitions for the CPU data-memory port: word width, FSM encoding,
// counter width and the address fault check.
package mem_if_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Misaligned, or any address bit above the word index is set.
    function automatic logic addr_fault(input logic [WORD_W-1:0] addr, input int idx_w);
        return (addr[1:0] != 2'b00) || ((addr >> (idx_w + 2)) != '0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: write on the clock edge, read port follows idx so the
// responder can capture the word on the same edge that commits a response.
module dmem_array
    import mem_if_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one word read/write per handshake, answered with a
// single-cycle valid_o strobe after LATENCY cycles.
//
// state | meaning
// IDLE  | ready for a request, no response pending
// WAIT  | request held, latency counter running, requests ignored
// RESP  | valid_o strobe cycle, may accept the next request back-to-back
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [WORD_W-1:0] data_o,
    output logic              err_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;

    logic              accept;
    logic              enter_resp;
    logic              cur_we;
    logic [WORD_W-1:0] cur_addr;
    logic [WORD_W-1:0] cur_wdata;
    logic              cur_fault;
    logic              ram_we;
    logic [WORD_W-1:0] ram_rdata;

    assign accept = req_i & ready_o;

    // With LATENCY=1 the response edge is the acceptance edge, so the
    // holding registers are not loaded yet and the live inputs are used.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (LATENCY == 1) begin
            cur_we    = we_i;
            cur_addr  = addr_i;
            cur_wdata = data_i;
        end
    end

    always_comb begin
        enter_resp = 1'b0;
        if (state_q == WAIT && cnt_q == CNT_W'(1)) begin
            enter_resp = 1'b1;
        end else if (LATENCY == 1 && accept) begin
            enter_resp = 1'b1;
        end
    end

    assign cur_fault = addr_fault(cur_addr, IDX_W);
    assign ram_we    = enter_resp & cur_we & ~cur_fault & ~rst_i;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i (clk_i),
        .we    (ram_we),
        .idx   (cur_addr[IDX_W+1:2]),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            data_o  <= '0;
            err_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;

            if (accept) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= data_i;
            end

            unique case (state_q)
                IDLE, RESP: begin
                    if (accept && LATENCY == 1) begin
                        state_q <= RESP;
                        ready_o <= 1'b1;
                    end else if (accept) begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_LOAD;
                        ready_o <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        ready_o <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= RESP;
                        ready_o <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_o <= 1'b1;
                end
            endcase

            if (enter_resp) begin
                valid_o <= 1'b1;
                err_o   <= cur_fault;
                data_o  <= (cur_we || cur_fault) ? '0 : ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder at LATENCY 2, 1 and 15.
module tb_data_mem_responder;

    localparam int LATS [3] = '{2, 1, 15};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  ready;
    logic [2:0]  valid;
    logic [2:0]  err;
    logic [31:0] dout [3];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            data_mem_responder #(
                .DEPTH   (256),
                .LATENCY (LATS[gi])
            ) u_dut (
                .clk_i   (clk),
                .rst_i   (rst),
                .req_i   (req[gi]),
                .we_i    (we),
                .addr_i  (addr),
                .data_i  (wdata),
                .ready_o (ready[gi]),
                .valid_o (valid[gi]),
                .data_o  (dout[gi]),
                .err_o   (err[gi])
            );
        end
    endgenerate

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t sb [$];
    int   n_asserts = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge; issues one request and returns at the negedge of
    // the response cycle so a following call lands back-to-back in RESP.
    task automatic xact(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e, input bit hold);
        exp_t e;
        int   lat;
        chk("ready_at_issue", 32'(ready[g]), 32'd1);
        we    = w;
        addr  = a;
        wdata = d;
        req[g] = 1'b1;
        sb.push_back(exp_t'{d: exp_d, e: exp_e});
        @(posedge clk);
        #1;
        if (!hold) req[g] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!valid[g] && hold) chk("ready_in_wait", 32'(ready[g]), 32'd0);
        end while (!valid[g] && lat < 40);
        req[g] = 1'b0;
        chk("latency", 32'(lat), 32'(LATS[g]));
        if (valid[g] && sb.size() > 0) begin
            e = sb.pop_front();
            chk("resp_data", dout[g], e.d);
            chk("resp_err", 32'(err[g]), 32'(e.e));
        end else begin
            chk("resp_valid", 32'(valid[g]), 32'd1);
        end
    endtask

    task automatic quiet(input int g, input int n);
        repeat (n) begin
            @(negedge clk);
            chk("no_valid", 32'(valid[g]), 32'd0);
            chk("err_idle", 32'(err[g]), 32'd0);
            chk("ready_idle", 32'(ready[g]), 32'd1);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("rst_ready", 32'(ready[g]), 32'd1);
            chk("rst_valid", 32'(valid[g]), 32'd0);
            chk("rst_data", dout[g], 32'd0);
            chk("rst_err", 32'(err[g]), 32'd0);
        end

        // LATENCY=2: write then read
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        quiet(0, 1);
        xact(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        @(negedge clk);
        chk("data_hold", dout[0], 32'hDEADBEEF);
        chk("hold_valid", 32'(valid[0]), 32'd0);

        // back-to-back read-after-write
        xact(0, 1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0, 1'b0);
        xact(0, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 1'b0);
        quiet(0, 1);

        // misaligned read and write leave 0x10 intact
        xact(0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b0);
        quiet(0, 1);
        xact(0, 1'b1, 32'h12, 32'h55555555, 32'h0, 1'b1, 1'b0);
        xact(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        quiet(0, 1);

        // out of range write must not wrap onto word 0
        xact(0, 1'b1, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
        quiet(0, 1);
        xact(0, 1'b1, 32'h400, 32'hFFFF0000, 32'h0, 1'b1, 1'b0);
        xact(0, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
        xact(0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1'b0);
        quiet(0, 1);

        // reset mid-WAIT drops the pending write
        xact(0, 1'b1, 32'h30, 32'h11111111, 32'h0, 1'b0, 1'b0);
        quiet(0, 1);
        we    = 1'b1;
        addr  = 32'h30;
        wdata = 32'hBAD0BAD0;
        req[0] = 1'b1;
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        @(negedge clk);
        chk("wait_ready", 32'(ready[0]), 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        quiet(0, 4);
        xact(0, 1'b0, 32'h30, 32'h0, 32'h11111111, 1'b0, 1'b0);
        quiet(0, 1);

        // LATENCY=1 with req held
        xact(1, 1'b1, 32'h8, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
        quiet(1, 3);
        xact(1, 1'b0, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        quiet(1, 2);
        xact(1, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 1'b0);
        quiet(1, 2);

        // LATENCY=15 with req held through WAIT
        xact(2, 1'b1, 32'h44, 32'h0BADF00D, 32'h0, 1'b0, 1'b1);
        quiet(2, 16);
        xact(2, 1'b0, 32'h44, 32'h0, 32'h0BADF00D, 1'b0, 1'b1);
        quiet(2, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

endmodule
